// File: rtl/seg_display_arbiter_if.sv
// ============================================================================
//  Module      : seg_display_arbiter_if
//  Description : Request/value bus between display requesters and the
//                seven-segment display arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seg_display_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int VAL_W   = 16
);
    localparam int OWN_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*VAL_W-1:0] value_in;
    logic [NUM_REQ-1:0]       grant;
    logic [OWN_W-1:0]         owner;
    logic [VAL_W-1:0]         disp_value;
    logic                     disp_valid;

    // Requester side
    modport master (
        output req, value_in,
        input  grant, owner, disp_value, disp_valid
    );

    // Arbiter side
    modport slave (
        input  req, value_in,
        output grant, owner, disp_value, disp_valid
    );
endinterface

`default_nettype wire

// File: rtl/seg_display_arbiter.sv
// ============================================================================
//  Module      : seg_display_arbiter
//  Description : Round-robin sharing of one 4-digit seven-segment display
//                among NUM_REQ requesters with a minimum readable hold time.
//                Optional macro SEG_ARB_PRIORITY_EN makes requester 0 urgent.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_display_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int VAL_W       = 16,
    parameter int HOLD_CYCLES = 25_000_000
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    seg_display_arbiter_if.slave   bus
);

    localparam int OWN_W = $clog2(NUM_REQ);
    localparam int HCW   = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANTED = 2'd1,
        S_SWITCH  = 2'd2
    } state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [OWN_W-1:0]   r_owner;
    logic [VAL_W-1:0]   r_disp_value;
    logic               r_disp_valid;
    logic [OWN_W-1:0]   r_rr_ptr;
    logic [HCW-1:0]     r_hold_cnt;

    logic [OWN_W-1:0]   w_pick;
    logic [NUM_REQ-1:0] w_pick_oh;
    logic               w_found;
    logic [OWN_W:0]     w_sum;
    logic [OWN_W-1:0]   w_idx;
    logic               w_any_req;
    logic [NUM_REQ-1:0] w_owner_oh;
    logic               w_owner_req;
    logic               w_others;
    logic [VAL_W-1:0]   w_owner_val;
    logic [OWN_W-1:0]   w_next_ptr;
    logic               w_hold_done;
    logic               w_preempt;
    logic               w_release;

    assign w_any_req = |bus.req;

    // Round-robin scan starting at r_rr_ptr; the sum stays below 2*NUM_REQ so one wrap suffices.
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (OWN_W+1)'(k);
            if (w_sum >= (OWN_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (OWN_W+1)'(NUM_REQ);
            end
            w_idx = w_sum[OWN_W-1:0];
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
`ifdef SEG_ARB_PRIORITY_EN
        if (bus.req[0]) begin
            w_pick = '0;
        end
`endif
    end

    always_comb begin
        w_pick_oh   = '0;
        w_owner_oh  = '0;
        w_owner_val = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_pick_oh[i]  = (w_pick == OWN_W'(i));
            w_owner_oh[i] = (r_owner == OWN_W'(i));
            if (r_owner == OWN_W'(i)) begin
                w_owner_val = bus.value_in[i*VAL_W +: VAL_W];
            end
        end
    end

    assign w_owner_req = |(bus.req & w_owner_oh);
    assign w_others    = |(bus.req & ~w_owner_oh);
    assign w_hold_done = (r_hold_cnt == HCW'(HOLD_CYCLES));
    assign w_next_ptr  = (r_owner == OWN_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

`ifdef SEG_ARB_PRIORITY_EN
    // Requester 0 cuts in at once; it is itself exempt from hold expiry.
    assign w_preempt = (r_owner != '0) &&
                       (bus.req[0] || (w_others && w_hold_done));
`else
    assign w_preempt = w_others && w_hold_done;
`endif

    // A drop wins over a simultaneous hold expiry; both leave through the same path.
    assign w_release = !w_owner_req || w_preempt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_owner      <= '0;
            r_disp_value <= '0;
            r_disp_valid <= 1'b0;
            r_rr_ptr     <= '0;
            r_hold_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_SWITCH: begin
                    r_hold_cnt <= '0;
                    if (w_any_req) begin
                        r_state      <= S_GRANTED;
                        r_owner      <= w_pick;
                        r_grant      <= w_pick_oh;
                        r_disp_valid <= 1'b1;
                    end else begin
                        r_state      <= S_IDLE;
                        r_grant      <= '0;
                        r_disp_valid <= 1'b0;
                    end
                end

                S_GRANTED: begin
                    r_disp_value <= w_owner_val;
                    if (w_release) begin
                        // Pointer moves on leaving so the blank SWITCH cycle can arbitrate directly.
                        r_state      <= w_others ? S_SWITCH : S_IDLE;
                        r_grant      <= '0;
                        r_disp_valid <= 1'b0;
                        r_rr_ptr     <= w_next_ptr;
                    end else if (!w_hold_done) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_grant      <= '0;
                    r_disp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant      = r_grant;
    assign bus.owner      = r_owner;
    assign bus.disp_value = r_disp_value;
    assign bus.disp_valid = r_disp_valid;

endmodule

`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
// ============================================================================
//  Module      : tb_seg_display_arbiter
//  Description : Self-checking bench for seg_display_arbiter (4 requesters,
//                HOLD_CYCLES=4) with a cycle-level behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_display_arbiter;

    localparam int NUM  = 4;
    localparam int VW   = 16;
    localparam int HOLD = 4;
`ifdef SEG_ARB_PRIORITY_EN
    localparam bit PRI = 1'b1;
`else
    localparam bit PRI = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    seg_display_arbiter_if #(.NUM_REQ(NUM), .VAL_W(VW)) bus ();

    seg_display_arbiter #(
        .NUM_REQ     (NUM),
        .VAL_W       (VW),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Behavioural model: who owns the display, how long, and where the scan resumes.
    int          m_owner = 0;
    int          m_hold  = 0;
    int          m_ptr   = 0;
    bit          m_gr    = 1'b0;
    logic [15:0] m_val   = '0;

    always @(posedge clk or negedge rst_n) begin : model
        logic [3:0] r;
        bit         others;
        if (!rst_n) begin
            m_owner = 0; m_hold = 0; m_ptr = 0; m_gr = 1'b0; m_val = '0;
        end else begin
            r = bus.req;
            if (m_gr) begin
                m_val  = bus.value_in[m_owner*VW +: VW];
                others = (r & ~(4'b0001 << m_owner)) != 4'b0000;
                if (!r[m_owner]
                    || (PRI && m_owner != 0 && r[0])
                    || (others && m_hold == HOLD && !(PRI && m_owner == 0))) begin
                    m_gr  = 1'b0;
                    m_ptr = (m_owner + 1) % NUM;
                end else if (m_hold < HOLD) begin
                    m_hold++;
                end
            end else if (r != 4'b0000) begin
                if (PRI && r[0]) begin
                    m_owner = 0;
                end else begin
                    for (int k = NUM - 1; k >= 0; k--) begin
                        if (r[(m_ptr + k) % NUM]) m_owner = (m_ptr + k) % NUM;
                    end
                end
                m_gr   = 1'b1;
                m_hold = 0;
            end
        end
    end

    always @(negedge clk) begin : compare
        chk("grant",      {28'd0, bus.grant},  m_gr ? (32'd1 << m_owner) : 32'd0);
        chk("owner",      {30'd0, bus.owner},  m_owner);
        chk("disp_valid", {31'd0, bus.disp_valid}, {31'd0, m_gr});
        chk("disp_value", {16'd0, bus.disp_value}, {16'd0, m_val});
    end

    task automatic tick(); @(negedge clk); endtask

    task automatic set_val(input int i, input logic [15:0] v);
        bus.value_in[i*VW +: VW] = v;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    int seq[$];
    logic [3:0] prev_grant;

    initial begin
        bus.req      = '0;
        bus.value_in = '0;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Idle after reset
        repeat (10) tick();
        chk("t1_grant", {28'd0, bus.grant}, 32'd0);
        chk("t1_value", {16'd0, bus.disp_value}, 32'd0);

        // Single requester, live value tracking
        set_val(1, 16'd1234);
        bus.req = 4'b0010;
        tick();
        chk("t2_grant", {28'd0, bus.grant}, 32'h2);
        chk("t2_owner", {30'd0, bus.owner}, 32'd1);
        chk("t2_valid", {31'd0, bus.disp_valid}, 32'd1);
        tick();
        chk("t2_val1234", {16'd0, bus.disp_value}, 32'd1234);
        set_val(1, 16'd99);
        tick();
        chk("t2_val99", {16'd0, bus.disp_value}, 32'd99);
        bus.req = 4'b0000;
        tick();
        chk("t2_release", {31'd0, bus.disp_valid}, 32'd0);

        // All requesting: owner order with blank gaps
        do_reset();
        bus.req    = 4'b1111;
        prev_grant = 4'b0000;
        for (int c = 0; c < 32; c++) begin
            tick();
            if (bus.grant != 4'b0000 && prev_grant == 4'b0000) seq.push_back(int'(bus.owner));
            prev_grant = bus.grant;
        end
        chk("t3_count", seq.size() >= 5 ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < 5 && i < seq.size(); i++) begin
            chk($sformatf("t3_owner%0d", i), seq[i], i % NUM);
        end
        bus.req = 4'b0000;
        tick();

        // Owner drop releases without waiting for hold
        do_reset();
        bus.req = 4'b0100;
        tick();
        bus.req = 4'b1100;
        tick();
        bus.req = 4'b1000;
        tick();
        chk("t4_switch_grant", {28'd0, bus.grant}, 32'd0);
        tick();
        chk("t4_grant3", {28'd0, bus.grant}, 32'h8);
        bus.req = 4'b0000;
        tick();
        chk("t4_idle_valid", {31'd0, bus.disp_valid}, 32'd0);

        // Asynchronous reset mid-grant
        bus.req = 4'b0010;
        tick();
        chk("t5_grant", {28'd0, bus.grant}, 32'h2);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_grant", {28'd0, bus.grant}, 32'd0);
        chk("t5_rst_owner", {30'd0, bus.owner}, 32'd0);
        chk("t5_rst_valid", {31'd0, bus.disp_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_regrant", {28'd0, bus.grant}, 32'h2);
        bus.req = 4'b0000;
        tick();

        // Urgent requester 0 versus hold-time round robin
        do_reset();
        bus.req = 4'b0100;
        tick();
        bus.req = 4'b1101;
`ifdef SEG_ARB_PRIORITY_EN
        tick();
        chk("t6_switch", {28'd0, bus.grant}, 32'd0);
        tick();
        chk("t6_grant0", {28'd0, bus.grant}, 32'h1);
`else
        repeat (4) tick();
        chk("t6_still2", {28'd0, bus.grant}, 32'h4);
        tick();
        chk("t6_switch", {28'd0, bus.grant}, 32'd0);
        tick();
        chk("t6_grant3", {28'd0, bus.grant}, 32'h8);
`endif
        bus.req = 4'b0000;
        tick();

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NUM; i++) begin
                if ($urandom_range(7) == 0) bus.req[i] = ~bus.req[i];
                if ($urandom_range(3) == 0) set_val(i, 16'($urandom));
            end
            if ($urandom_range(299) == 0) do_reset();
            else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
